// File: rtl/ult_meter_bank.sv
// N-player ultimate-charge meter bank: per-channel charge/ready/use FSM with
// health-scaled charge rate, hit drain and a shared blink for full meters.
module ult_meter_bank #(
  parameter int NUM_PLAYERS = 2,
  parameter int SEGS        = 8,
  parameter int HEALTH_W    = 4,
  parameter int TICK_SHIFT  = 22,
  parameter int BLINK_MAX   = 9999999,
  parameter int HIT_DRAIN   = 1,
  localparam int LW         = $clog2(SEGS + 1)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_PLAYERS*HEALTH_W-1:0] health,
  input  logic [NUM_PLAYERS-1:0]          use_req,
  input  logic [NUM_PLAYERS-1:0]          hit,
  output logic [NUM_PLAYERS*SEGS-1:0]     led,
  output logic [NUM_PLAYERS*LW-1:0]       level,
  output logic [NUM_PLAYERS-1:0]          ult_ready,
  output logic [NUM_PLAYERS-1:0]          use_ack
);

  localparam int CW = HEALTH_W + TICK_SHIFT;
  localparam int BW = (BLINK_MAX > 0) ? $clog2(BLINK_MAX + 1) : 1;

  typedef enum logic [1:0] {DEAD, CHARGING, READY} state_t;

  function automatic logic [LW-1:0] drain(input logic [LW-1:0] v);
    return (int'(v) > HIT_DRAIN) ? v - LW'(HIT_DRAIN) : '0;
  endfunction

  function automatic logic [SEGS-1:0] thermo(input logic [LW-1:0] v);
    logic [SEGS-1:0] t;
    for (int i = 0; i < SEGS; i++) t[i] = (i < int'(v));
    return t;
  endfunction

  logic [BW-1:0] blink_cnt;
  logic          blink;
  logic          blink_wrap;
  logic          blink_nxt;

  assign blink_wrap = (blink_cnt == BW'(BLINK_MAX));
  // Full meters load the post-edge blink value so led flips on the same edge as blink.
  assign blink_nxt  = blink ^ blink_wrap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else if (blink_wrap) begin
      blink_cnt <= '0;
      blink     <= ~blink;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_ch
    state_t              state;
    logic [LW-1:0]       lvl;
    logic [CW-1:0]       cnt;
    logic [CW-1:0]       limit;
    logic [HEALTH_W-1:0] h;
    logic                tick;
    logic [LW-1:0]       lvl_inc;
    logic [LW-1:0]       lvl_chg;
    logic [LW-1:0]       lvl_hit_full;
    logic [SEGS-1:0]     led_q;
    logic                rdy_q;
    logic                ack_q;

    assign h            = health[p*HEALTH_W +: HEALTH_W];
    assign limit        = {h, {TICK_SHIFT{1'b0}}} - CW'(1);
    assign tick         = (cnt >= limit);
    assign lvl_inc      = tick ? lvl + LW'(1) : lvl;
    assign lvl_chg      = hit[p] ? drain(lvl_inc) : lvl_inc;
    assign lvl_hit_full = drain(LW'(SEGS));

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state <= CHARGING;
        lvl   <= '0;
        cnt   <= '0;
        led_q <= '0;
        rdy_q <= 1'b0;
        ack_q <= 1'b0;
      end else begin
        // NOTE: default-low here, overridden only on acceptance, makes ack a one-cycle pulse.
        ack_q <= 1'b0;
        if (h == '0) begin
          state <= DEAD;
          lvl   <= '0;
          cnt   <= '0;
          led_q <= '0;
          rdy_q <= 1'b0;
        end else begin
          unique case (state)
            CHARGING: begin
              lvl <= lvl_chg;
              cnt <= tick ? '0 : cnt + CW'(1);
              if (int'(lvl_chg) == SEGS) begin
                state <= READY;
                led_q <= {SEGS{blink_nxt}};
                rdy_q <= 1'b1;
              end else begin
                led_q <= thermo(lvl_chg);
                rdy_q <= 1'b0;
              end
            end
            READY: begin
              cnt <= '0;
              if (use_req[p]) begin
                state <= CHARGING;
                lvl   <= '0;
                led_q <= '0;
                rdy_q <= 1'b0;
                ack_q <= 1'b1;
              end else if (hit[p]) begin
                state <= CHARGING;
                lvl   <= lvl_hit_full;
                led_q <= thermo(lvl_hit_full);
                rdy_q <= 1'b0;
              end else begin
                led_q <= {SEGS{blink_nxt}};
                rdy_q <= 1'b1;
              end
            end
            default: begin
              state <= CHARGING;
              lvl   <= '0;
              cnt   <= '0;
              led_q <= '0;
              rdy_q <= 1'b0;
            end
          endcase
        end
      end
    end

    assign led[p*SEGS +: SEGS] = led_q;
    assign level[p*LW +: LW]   = lvl;
    assign ult_ready[p]        = rdy_q;
    assign use_ack[p]          = ack_q;
  end

endmodule

// File: tb/tb_ult_meter_bank.sv
// Self-checking bench for ult_meter_bank: directed scenarios plus randomized
// traffic against an integer-arithmetic reference model of the meter rules.
module tb_ult_meter_bank;

  localparam int NP   = 2;
  localparam int SEGS = 4;
  localparam int HW   = 4;
  localparam int TS   = 2;
  localparam int BM   = 3;
  localparam int HD   = 1;
  localparam int LW   = 3;

  localparam int M_DEAD = 0;
  localparam int M_CH   = 1;
  localparam int M_RDY  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NP*HW-1:0]  health;
  logic [NP-1:0]     use_req;
  logic [NP-1:0]     hit;
  wire  [NP*SEGS-1:0] led;
  wire  [NP*LW-1:0]  level;
  wire  [NP-1:0]     ult_ready;
  wire  [NP-1:0]     use_ack;

  int errors = 0;
  int checks = 0;

  int ms[NP];
  int ml[NP];
  int mc[NP];
  bit mack[NP];
  int bcnt;
  bit mblink;

  ult_meter_bank #(
    .NUM_PLAYERS(NP), .SEGS(SEGS), .HEALTH_W(HW), .TICK_SHIFT(TS),
    .BLINK_MAX(BM), .HIT_DRAIN(HD)
  ) dut (
    .clk(clk), .reset(reset), .health(health), .use_req(use_req), .hit(hit),
    .led(led), .level(level), .ult_ready(ult_ready), .use_ack(use_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [NP*SEGS-1:0] exp_led();
    logic [NP*SEGS-1:0] v = '0;
    for (int p = 0; p < NP; p++)
      if (ms[p] == M_RDY) v[p*SEGS +: SEGS] = mblink ? 4'hf : 4'h0;
      else                v[p*SEGS +: SEGS] = 4'((1 << ml[p]) - 1);
    return v;
  endfunction

  function automatic logic [NP*LW-1:0] exp_level();
    logic [NP*LW-1:0] v = '0;
    for (int p = 0; p < NP; p++) v[p*LW +: LW] = 3'(ml[p]);
    return v;
  endfunction

  function automatic logic [NP-1:0] exp_ready();
    logic [NP-1:0] v = '0;
    for (int p = 0; p < NP; p++) v[p] = (ms[p] == M_RDY);
    return v;
  endfunction

  function automatic logic [NP-1:0] exp_ack();
    logic [NP-1:0] v = '0;
    for (int p = 0; p < NP; p++) v[p] = mack[p];
    return v;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      ms[p] = M_CH; ml[p] = 0; mc[p] = 0; mack[p] = 1'b0;
    end
    bcnt = 0;
    mblink = 1'b0;
  endtask

  // Advance the reference model by one clock using the inputs now applied.
  task automatic model_step();
    if (bcnt == BM) begin
      mblink = !mblink;
      bcnt = 0;
    end else begin
      bcnt++;
    end
    for (int p = 0; p < NP; p++) begin
      int h;
      h = int'(health[p*HW +: HW]);
      mack[p] = 1'b0;
      if (h == 0) begin
        ms[p] = M_DEAD; ml[p] = 0; mc[p] = 0;
      end else if (ms[p] == M_DEAD) begin
        ms[p] = M_CH; ml[p] = 0; mc[p] = 0;
      end else if (ms[p] == M_RDY) begin
        mc[p] = 0;
        if (use_req[p]) begin
          mack[p] = 1'b1; ml[p] = 0; ms[p] = M_CH;
        end else if (hit[p]) begin
          ml[p] = (SEGS - HD < 0) ? 0 : SEGS - HD;
          ms[p] = M_CH;
        end
      end else begin
        if (mc[p] >= (h << TS) - 1) begin
          ml[p]++;
          mc[p] = 0;
        end else begin
          mc[p]++;
        end
        if (hit[p]) ml[p] = (ml[p] - HD < 0) ? 0 : ml[p] - HD;
        if (ml[p] == SEGS) ms[p] = M_RDY;
      end
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input logic [NP*HW-1:0] h);
    reset = 1'b1;
    use_req = '0;
    hit = '0;
    health = h;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_level(input int ch, input int target);
    int n = 0;
    while (int'(level[ch*LW +: LW]) != target && n < 200) begin
      step();
      n++;
    end
    if (int'(level[ch*LW +: LW]) != target) begin
      checks++; errors++;
      $display("FAIL wait_level ch%0d: level=%0d never reached %0d", ch, level[ch*LW +: LW], target);
    end
  endtask

  task automatic wait_ready(input int ch);
    int n = 0;
    while (!ult_ready[ch] && n < 200) begin
      step();
      n++;
    end
    if (!ult_ready[ch]) begin
      checks++; errors++;
      $display("FAIL wait_ready ch%0d: ult_ready stayed 0", ch);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    health = '0;
    use_req = '0;
    hit = '0;
    model_reset();
    #13;
    checks++;
    if ({led, level, ult_ready, use_ack} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: led=%h level=%h rdy=%b ack=%b, want all 0", led, level, ult_ready, use_ack);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_charge_blink();
    apply_reset(8'h01);
    for (int k = 1; k <= 24; k++) begin
      step();
      checks++;
      if ({led, level, ult_ready, use_ack} !== {exp_led(), exp_level(), exp_ready(), exp_ack()}) begin
        errors++;
        $display("FAIL charge_model k=%0d: led=%h/%h level=%h/%h rdy=%b/%b", k, led, exp_led(), level, exp_level(), ult_ready, exp_ready());
      end
      if (k % 4 == 0 && k <= 16) begin
        checks++;
        if (int'(level[2:0]) != k / 4) begin
          errors++;
          $display("FAIL charge_level k=%0d: level0=%0d want %0d", k, level[2:0], k / 4);
        end
      end
      if (k == 16) begin
        checks++;
        if (ult_ready[0] !== 1'b1) begin
          errors++;
          $display("FAIL charge_ready: ult_ready0=%b want 1", ult_ready[0]);
        end
      end
      if (k >= 16) begin
        checks++;
        if (led[3:0] !== (((k / 4) % 2 == 1) ? 4'hf : 4'h0)) begin
          errors++;
          $display("FAIL blink k=%0d: led0=%b want %b", k, led[3:0], ((k / 4) % 2 == 1) ? 4'hf : 4'h0);
        end
      end
    end
  endtask

  task automatic test_use_accept();
    int acks = 0;
    wait_ready(0);
    use_req[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (use_ack[0]) acks++;
      if (i == 0) begin
        checks++;
        if ({use_ack[0], level[2:0], led[3:0], ult_ready[0]} !== {1'b1, 3'd0, 4'h0, 1'b0}) begin
          errors++;
          $display("FAIL use_accept: ack=%b level=%0d led=%b rdy=%b want 1/0/0000/0", use_ack[0], level[2:0], led[3:0], ult_ready[0]);
        end
      end
    end
    use_req[0] = 1'b0;
    checks++;
    if (acks != 1) begin
      errors++;
      $display("FAIL use_ack_count: acks=%0d want 1", acks);
    end
  endtask

  task automatic test_use_ignored();
    wait_level(0, 2);
    use_req[0] = 1'b1;
    step();
    use_req[0] = 1'b0;
    checks++;
    if ({use_ack[0], level[2:0]} !== {1'b0, 3'd2}) begin
      errors++;
      $display("FAIL use_ignored: ack=%b level=%0d want 0/2", use_ack[0], level[2:0]);
    end
  endtask

  task automatic test_hit();
    apply_reset(8'h01);
    hit[0] = 1'b1;
    step();
    hit[0] = 1'b0;
    checks++;
    if (level[2:0] !== 3'd0) begin
      errors++;
      $display("FAIL hit_at_zero: level0=%0d want 0", level[2:0]);
    end
    wait_level(0, 2);
    hit[0] = 1'b1;
    step();
    hit[0] = 1'b0;
    checks++;
    if (level[2:0] !== 3'd1) begin
      errors++;
      $display("FAIL hit_drain: level0=%0d want 1", level[2:0]);
    end
    wait_ready(0);
    hit[0] = 1'b1;
    step();
    hit[0] = 1'b0;
    checks++;
    if ({level[2:0], ult_ready[0], led[3:0]} !== {3'd3, 1'b0, 4'b0111}) begin
      errors++;
      $display("FAIL hit_ready: level=%0d rdy=%b led=%b want 3/0/0111", level[2:0], ult_ready[0], led[3:0]);
    end
    apply_reset(8'h01);
    wait_level(0, 2);
    for (int i = 0; i < 3; i++) step();
    hit[0] = 1'b1;
    step();
    hit[0] = 1'b0;
    checks++;
    if (level[2:0] !== 3'd2) begin
      errors++;
      $display("FAIL tick_plus_hit: level0=%0d want 2", level[2:0]);
    end
  endtask

  task automatic test_death();
    apply_reset(8'h01);
    wait_level(0, 3);
    health[3:0] = 4'd0;
    step();
    checks++;
    if ({level[2:0], led[3:0], ult_ready[0]} !== {3'd0, 4'h0, 1'b0}) begin
      errors++;
      $display("FAIL death: level=%0d led=%b rdy=%b want 0/0000/0", level[2:0], led[3:0], ult_ready[0]);
    end
    health[3:0] = 4'd2;
    for (int k = 1; k <= 9; k++) begin
      step();
      if (k == 8 || k == 9) begin
        checks++;
        if (int'(level[2:0]) != k - 8) begin
          errors++;
          $display("FAIL revive_tick k=%0d: level0=%0d want %0d", k, level[2:0], k - 8);
        end
      end
    end
    wait_ready(0);
    use_req[0] = 1'b1;
    hit[0] = 1'b1;
    step();
    use_req[0] = 1'b0;
    hit[0] = 1'b0;
    checks++;
    if ({use_ack[0], level[2:0], ult_ready[0]} !== {1'b1, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL use_beats_hit: ack=%b level=%0d rdy=%b want 1/0/0", use_ack[0], level[2:0], ult_ready[0]);
    end
  endtask

  task automatic test_independence();
    apply_reset(8'h31);
    for (int i = 0; i < 10; i++) step();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({led, level, ult_ready, use_ack} !== '0) begin
      errors++;
      $display("FAIL async_reset: led=%h level=%h rdy=%b ack=%b want all 0", led, level, ult_ready, use_ack);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      step();
      checks++;
      if ({led, level, ult_ready, use_ack} !== {exp_led(), exp_level(), exp_ready(), exp_ack()}) begin
        errors++;
        $display("FAIL indep_model k=%0d: led=%h/%h level=%h/%h rdy=%b/%b ack=%b/%b", k, led, exp_led(), level, exp_level(), ult_ready, exp_ready(), use_ack, exp_ack());
      end
      if (k % 12 == 0) begin
        checks++;
        if (int'(level[5:3]) != ((k / 12 > 4) ? 4 : k / 12)) begin
          errors++;
          $display("FAIL ch1_rate k=%0d: level1=%0d want %0d", k, level[5:3], k / 12);
        end
      end
      if (k == 48) begin
        checks++;
        if (ult_ready[1] !== 1'b1) begin
          errors++;
          $display("FAIL ch1_ready: ult_ready1=%b want 1", ult_ready[1]);
        end
      end
      use_req[0] = ($urandom_range(0, 3) == 0);
      hit[0]     = ($urandom_range(0, 3) == 0);
    end
    use_req = '0;
    hit = '0;
  endtask

  task automatic test_random();
    apply_reset({4'($urandom_range(1, 3)), 4'($urandom_range(1, 3))});
    for (int k = 0; k < 1500; k++) begin
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(0, 63) == 0) health[p*HW +: HW] = 4'($urandom_range(0, 4));
        use_req[p] = ($urandom_range(0, 7) == 0);
        hit[p]     = ($urandom_range(0, 15) == 0);
      end
      step();
      checks++;
      if ({led, level, ult_ready, use_ack} !== {exp_led(), exp_level(), exp_ready(), exp_ack()}) begin
        errors++;
        $display("FAIL random k=%0d: led=%h/%h level=%h/%h rdy=%b/%b ack=%b/%b", k, led, exp_led(), level, exp_level(), ult_ready, exp_ready(), use_ack, exp_ack());
      end
    end
    use_req = '0;
    hit = '0;
  endtask

  initial begin
    test_reset();
    test_charge_blink();
    test_use_accept();
    test_use_ignored();
    test_hit();
    test_death();
    test_independence();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
